// File: rtl/stack_arbiter_pkg.sv
// Shared definitions for the stack arbiter slice.
//   OP_PUSH / OP_POP : encoding of the per-requester req_op bit
//   rsp_t            : registered response record (requester id, op, error)
package stack_arb_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    // Id field is sized for up to 16 requesters; narrower indices are zero-extended.
    localparam int unsigned ID_W = 4;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            op;
        logic            err;
    } rsp_t;

endpackage

// File: rtl/stack_arbiter_if.sv
// Requester-side bus of the stack arbiter.
//   req_valid/req_ready/req_op/req_data : per-requester request handshake
//   rsp_valid/rsp_err/rsp_data          : response, one cycle after acceptance
// master = requesters, slave = arbiter.
interface stack_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_op;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    rsp_valid;
    logic               rsp_err;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rsp_valid, rsp_err, rsp_data
    );
endinterface

// File: rtl/stack_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index of the last winner; search starts at ptr+1 and wraps
//   grant : one-hot grant (zero when no request)
//   idx   : index of the granted requester
//   any   : at least one request present
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin : arb
        logic [IW-1:0] cand;
        cand  = '0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IW'((32'(ptr) + off) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack between NREQ requesters.
//   clk, rst          : clock, asynchronous active-low reset
//   flush             : synchronous stack flush (count to 0, stack reset)
//   bus               : requester bus (slave side), see stack_arbiter_if
//   st_rst/st_push/st_pop/st_wdata/st_rdata : stack control and data
//   full, empty       : occupancy flags
// One op is issued per cycle to the round-robin winner; push-on-full and
// pop-on-empty are accepted but dropped and answered with rsp_err=1.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    stack_arbiter_if.slave bus,
    output logic           st_rst,
    output logic           st_push,
    output logic           st_pop,
    output logic [DW-1:0]  st_wdata,
    input  logic [DW-1:0]  st_rdata,
    output logic           full,
    output logic           empty
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   rr_ptr;
    logic            any_req;
    logic            hs;
    logic            win_op;
    logic            reject;
    logic [DW-1:0]   win_data;
    logic [CW-1:0]   count;
    rsp_t            rsp_q;
    logic            rsp_vld_q;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (any_req)
    );

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Issue: the handshake itself is the stack command, so the stack
    // samples push/pop on the same edge the requester is accepted.
    always_comb begin
        win_op   = OP_PUSH;
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_op   = bus.req_op[i];
                win_data = bus.req_data[i*DW +: DW];
            end
        end
        // rst gating forces ready/push/pop low while reset is asserted.
        hs            = any_req & rst & ~flush;
        reject        = (win_op == OP_PUSH) ? full : empty;
        bus.req_ready = hs ? grant : '0;
        st_push       = hs & (win_op == OP_PUSH) & ~full;
        st_pop        = hs & (win_op == OP_POP) & ~empty;
        st_wdata      = st_push ? win_data : '0;
        st_rst        = ~rst | flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= IW'(NREQ - 1);
        end else if (hs) begin
            rr_ptr <= win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (st_push) begin
            count <= count + CW'(1);
        end else if (st_pop) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld_q <= 1'b0;
            rsp_q     <= '0;
        end else begin
            rsp_vld_q <= hs;
            if (hs) begin
                rsp_q <= '{id: ID_W'(win_idx), op: win_op, err: reject};
            end
        end
    end

    // Pop data is not registered here: the stack presents the popped word
    // in the response cycle and it is passed straight through.
    always_comb begin
        bus.rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            bus.rsp_valid[i] = rsp_vld_q && (rsp_q.id == ID_W'(i));
        end
        bus.rsp_err  = rsp_vld_q & rsp_q.err;
        bus.rsp_data = (rsp_vld_q && rsp_q.op == OP_POP && !rsp_q.err) ? st_rdata : '0;
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter (NREQ=2, DW=8, DEPTH=4) with a behavioural stack.
// Reference model: a queue for the stack contents and a last-winner index.
module tb_stack_arbiter;

    localparam int NREQ  = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       st_rst, st_push, st_pop, full, empty;
    logic [7:0] st_wdata;
    logic [7:0] st_rdata = '0;

    stack_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    stack_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus.slave),
        .st_rst   (st_rst),
        .st_push  (st_push),
        .st_pop   (st_pop),
        .st_wdata (st_wdata),
        .st_rdata (st_rdata),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    // Behavioural LIFO: sync active-high reset, popped word registered.
    logic [7:0] mem [DEPTH];
    int         sp = 0;
    always @(posedge clk) begin
        if (st_rst) begin
            sp <= 0;
        end else if (st_push) begin
            if (sp < DEPTH) mem[sp] <= st_wdata;
            sp <= sp + 1;
        end else if (st_pop) begin
            if (sp > 0) st_rdata <= mem[sp-1];
            sp <= sp - 1;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state and per-cycle expectations.
    logic [7:0]  m_q[$];
    int          m_ptr;
    int          m_win;
    logic [1:0]  e_ready, e_rv;
    logic        e_push, e_pop, e_err;
    logic [7:0]  e_wdata, e_data;
    // pre-edge:  {ready[1:0], push, pop, wdata[7:0], st_rst}
    // post-edge: {rsp_valid[1:0], err, data[7:0], full, empty}
    logic [12:0] o_pre, e_pre, o_post, e_post;

    task automatic set_req(input int i, input logic v, input logic op, input logic [7:0] d);
        bus.req_valid[i]          = v;
        bus.req_op[i]             = op;
        bus.req_data[i*DW +: DW]  = d;
    endtask

    // Advance one cycle from a falling edge: sample the combinational
    // side before the rising edge, predict with the model, sample the
    // registered side after the edge, and return at the next falling edge.
    task automatic tick();
        #1;
        o_pre = {bus.req_ready, st_push, st_pop, st_wdata, st_rst};
        e_ready = '0; e_rv = '0; e_push = 1'b0; e_pop = 1'b0;
        e_err = 1'b0; e_wdata = '0; e_data = '0; m_win = -1;
        if (rst && !flush) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (m_win < 0 && bus.req_valid[c]) m_win = c;
            end
        end
        if (!rst) begin
            m_q.delete();
            m_ptr = NREQ - 1;
        end else if (flush) begin
            m_q.delete();
        end else if (m_win >= 0) begin
            logic [7:0] d;
            d = bus.req_data[m_win*DW +: DW];
            e_ready[m_win] = 1'b1;
            e_rv[m_win]    = 1'b1;
            m_ptr          = m_win;
            if (bus.req_op[m_win] == 1'b0) begin
                if (m_q.size() == DEPTH) e_err = 1'b1;
                else begin
                    m_q.push_back(d);
                    e_push  = 1'b1;
                    e_wdata = d;
                end
            end else begin
                if (m_q.size() == 0) e_err = 1'b1;
                else begin
                    e_data = m_q.pop_back();
                    e_pop  = 1'b1;
                end
            end
        end
        e_pre  = {e_ready, e_push, e_pop, e_wdata, (!rst || flush)};
        e_post = {e_rv, e_err, e_data, (m_q.size() == DEPTH), (m_q.size() == 0)};
        @(posedge clk);
        #1;
        o_post = {bus.rsp_valid, bus.rsp_err, bus.rsp_data, full, empty};
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 1'b0, 8'h10 + 8'(k));
            tick();
            checks += 2;
            if (o_pre !== e_pre) begin errors++; $display("FAIL reset_fill pre got %h want %h", o_pre, e_pre); end
            if (o_post !== e_post) begin errors++; $display("FAIL reset_fill post got %h want %h", o_post, e_post); end
        end
        // Stack full, response pending, push request held: drop reset between edges.
        set_req(1, 1'b1, 1'b1, 8'h00);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data, st_push, st_pop, st_wdata, st_rst, full, empty}
            !== {2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_async got rdy=%b rv=%b err=%b d=%h push=%b pop=%b wd=%h strst=%b full=%b empty=%b",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data, st_push, st_pop, st_wdata, st_rst, full, empty);
        end
        @(posedge clk);
        @(negedge clk);
        m_q.delete();
        m_ptr = NREQ - 1;
        rst   = 1'b1;
        // Both valid after reset: requester 0 must win first (pop on empty -> error).
        set_req(0, 1'b1, 1'b1, 8'h00);
        tick();
        checks += 3;
        if (o_pre[12:11] !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", o_pre[12:11]); end
        if (o_pre !== e_pre) begin errors++; $display("FAIL reset_after pre got %h want %h", o_pre, e_pre); end
        if (o_post !== e_post) begin errors++; $display("FAIL reset_after post got %h want %h", o_post, e_post); end
        bus.req_valid = '0;
    endtask

    task automatic test_push_pop();
        logic [7:0] want;
        bus.req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) set_req(0, 1'b1, 1'b0, 8'(k + 1));
            else       set_req(0, 1'b1, 1'b1, 8'h00);
            want = (k < 3) ? 8'h00 : 8'(6 - k);
            tick();
            checks += 3;
            if (o_pre !== e_pre) begin errors++; $display("FAIL push_pop pre k=%0d got %h want %h", k, o_pre, e_pre); end
            if (o_post !== e_post) begin errors++; $display("FAIL push_pop post k=%0d got %h want %h", k, o_post, e_post); end
            if ({o_post[12:11], o_post[10], o_post[9:2]} !== {2'b01, 1'b0, want}) begin
                errors++;
                $display("FAIL push_pop rsp k=%0d got rv=%b err=%b d=%h want rv=01 err=0 d=%h",
                         k, o_post[12:11], o_post[10], o_post[9:2], want);
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_alternate();
        int         acc = 0;
        logic [7:0] n0 = 8'hA0, n1 = 8'hB0;
        logic [1:0] prev = '0;
        set_req(0, 1'b1, 1'b0, n0);
        set_req(1, 1'b1, 1'b0, n1);
        for (int cyc = 0; cyc < 8 && acc < 4; cyc++) begin
            tick();
            checks += 2;
            if (o_pre !== e_pre) begin errors++; $display("FAIL alternate pre cyc=%0d got %h want %h", cyc, o_pre, e_pre); end
            if (o_post !== e_post) begin errors++; $display("FAIL alternate post cyc=%0d got %h want %h", cyc, o_post, e_post); end
            if (cyc > 0) begin
                checks++;
                if (o_pre[12:11] === prev) begin errors++; $display("FAIL alternate_rr cyc=%0d got %b want not %b", cyc, o_pre[12:11], prev); end
            end
            prev = o_pre[12:11];
            if (m_win == 0) begin n0++; set_req(0, 1'b1, 1'b0, n0); acc++; end
            if (m_win == 1) begin n1++; set_req(1, 1'b1, 1'b0, n1); acc++; end
        end
        checks++;
        if (o_post[1] !== 1'b1) begin errors++; $display("FAIL alternate_full got %b want 1", o_post[1]); end
        bus.req_valid = '0;
    endtask

    task automatic test_overflow_underflow();
        set_req(0, 1'b1, 1'b0, 8'hEE);
        tick();
        checks += 3;
        if (o_pre !== e_pre) begin errors++; $display("FAIL overflow pre got %h want %h", o_pre, e_pre); end
        if (o_post !== e_post) begin errors++; $display("FAIL overflow post got %h want %h", o_post, e_post); end
        if ({o_pre[10], o_post[10], o_post[9:2], o_post[1]} !== {1'b0, 1'b1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL overflow_err got push=%b err=%b d=%h full=%b want 0 1 00 1",
                     o_pre[10], o_post[10], o_post[9:2], o_post[1]);
        end
        bus.req_valid = '0;
        set_req(1, 1'b1, 1'b1, 8'h00);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks += 2;
            if (o_pre !== e_pre) begin errors++; $display("FAIL drain pre k=%0d got %h want %h", k, o_pre, e_pre); end
            if (o_post !== e_post) begin errors++; $display("FAIL drain post k=%0d got %h want %h", k, o_post, e_post); end
        end
        checks++;
        if ({o_pre[9], o_post[12:11], o_post[10], o_post[9:2]} !== {1'b0, 2'b10, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL underflow_err got pop=%b rv=%b err=%b d=%h want 0 10 1 00",
                     o_pre[9], o_post[12:11], o_post[10], o_post[9:2]);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, 1'b0, 8'h50 + 8'(k));
            tick();
            checks += 2;
            if (o_pre !== e_pre) begin errors++; $display("FAIL flush_fill pre got %h want %h", o_pre, e_pre); end
            if (o_post !== e_post) begin errors++; $display("FAIL flush_fill post got %h want %h", o_post, e_post); end
        end
        set_req(0, 1'b1, 1'b1, 8'h00);
        flush = 1'b1;
        tick();
        checks += 3;
        if (o_pre !== e_pre) begin errors++; $display("FAIL flush pre got %h want %h", o_pre, e_pre); end
        if (o_post !== e_post) begin errors++; $display("FAIL flush post got %h want %h", o_post, e_post); end
        if ({o_pre[12:9], o_pre[0], o_post[0]} !== {4'b0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL flush_state got rdy=%b push=%b pop=%b st_rst=%b empty=%b want 00 0 0 1 1",
                     o_pre[12:11], o_pre[10], o_pre[9], o_pre[0], o_post[0]);
        end
        flush = 1'b0;
        tick();
        checks += 2;
        if (o_post !== e_post) begin errors++; $display("FAIL flush_pop post got %h want %h", o_post, e_post); end
        if (o_post[10] !== 1'b1) begin errors++; $display("FAIL flush_pop_err got %b want 1", o_post[10]); end
        bus.req_valid = '0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            set_req(1, 1'b1, 1'(k % 2), 8'h11);
            tick();
            checks += 3;
            if (o_pre !== e_pre) begin errors++; $display("FAIL b2b pre k=%0d got %h want %h", k, o_pre, e_pre); end
            if (o_post !== e_post) begin errors++; $display("FAIL b2b post k=%0d got %h want %h", k, o_post, e_post); end
            if ({o_post[12:11], o_post[10], o_post[9:2], o_post[0]}
                !== {2'b10, 1'b0, ((k % 2 == 1) ? 8'h11 : 8'h00), 1'(k % 2)}) begin
                errors++;
                $display("FAIL b2b rsp k=%0d got rv=%b err=%b d=%h empty=%b", k, o_post[12:11], o_post[10], o_post[9:2], o_post[0]);
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 3) != 0)
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
            flush = ($urandom_range(0, 24) == 0);
            tick();
            checks += 2;
            if (o_pre !== e_pre) begin errors++; $display("FAIL random pre cyc=%0d got %h want %h", cyc, o_pre, e_pre); end
            if (o_post !== e_post) begin errors++; $display("FAIL random post cyc=%0d got %h want %h", cyc, o_post, e_post); end
            if (m_win >= 0) bus.req_valid[m_win] = 1'b0;
        end
        flush = 1'b0;
        bus.req_valid = '0;
    endtask

    initial begin
        rst           = 1'b0;
        flush         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_data  = '0;
        m_ptr         = NREQ - 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_push_pop();
        test_alternate();
        test_overflow_underflow();
        test_flush();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
